// File: rtl/hack_screen_scanout_pkg.sv
// Shared types and screen geometry for the Hack screen scan-out reader.
package hack_screen_scanout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    localparam logic [15:0] SCREEN_BASE  = 16'h4000;
    localparam int          SCREEN_WORDS = 8192;
    localparam int          SCREEN_W     = 512;
    localparam int          SCREEN_H     = 256;
    localparam int          PIX_PER_WORD = 16;

endpackage

// File: rtl/hack_screen_scanout_shifter.sv
// Word-to-pixel serializer: loads one screen word and emits it LSB first,
// applying the optional polarity inversion on the way out.
module hack_pixel_shifter
    import hack_screen_scanout_pkg::*;
#(
    parameter bit INVERT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [15:0] i_data,
    input  logic        i_shift,
    output logic        o_pix,
    output logic        o_empty,
    output logic        o_full,
    output logic        o_last
);

    localparam logic [4:0] LP_FULL = 5'(PIX_PER_WORD);

    logic [15:0] r_shreg;
    logic [4:0]  r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= 16'h0000;
            r_cnt   <= 5'd0;
        end else if (i_load) begin
            r_shreg <= i_data;
            r_cnt   <= LP_FULL;
        end else if (i_shift && (r_cnt != 5'd0)) begin
            r_shreg <= {1'b0, r_shreg[15:1]};
            r_cnt   <= r_cnt - 5'd1;
        end
    end

    assign o_pix   = r_shreg[0] ^ INVERT;
    assign o_empty = (r_cnt == 5'd0);
    assign o_full  = (r_cnt == LP_FULL);
    assign o_last  = (r_cnt == 5'd1);

endmodule

// File: rtl/hack_screen_scanout.sv
// Raster scan-out of Hack screen RAM into a valid/ready pixel stream with
// line and frame blanking.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for enable, counters cleared
// ST_FETCH  | one-cycle read request for the current word
// ST_WAIT   | waiting for mem_rvalid, then load the shifter
// ST_SHIFT  | presenting pixels until all 16 are accepted
// ST_HBLANK | idle cycles after each scanline
// ST_VBLANK | idle cycles after the last scanline of a frame
module hack_screen_scanout
    import hack_screen_scanout_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = SCREEN_BASE,
    parameter int          WORDS_PER_LINE = SCREEN_W / PIX_PER_WORD,
    parameter int          LINES          = SCREEN_H,
    parameter int          HBLANK         = 4,
    parameter int          VBLANK         = 16,
    parameter bit          INVERT         = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_rvalid,
    output logic        o_pix_valid,
    output logic        o_pix_data,
    input  logic        i_pix_ready,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam logic [15:0] LP_WPL       = 16'(WORDS_PER_LINE);
    localparam logic [15:0] LP_WORD_LAST = 16'(WORDS_PER_LINE - 1);
    localparam logic [15:0] LP_LINE_LAST = 16'(LINES - 1);
    localparam logic [15:0] LP_HB_LOAD   = 16'(HBLANK - 1);
    localparam logic [15:0] LP_VB_LOAD   = 16'(VBLANK - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_word;
    logic [15:0] r_line;
    logic [15:0] r_tmr;

    logic        w_pix;
    logic        w_empty;
    logic        w_full;
    logic        w_last;
    logic        w_load;
    logic        w_pix_valid;
    logic        w_accept;
    logic        w_word_done;
    logic        w_tmr_done;
    logic [15:0] w_addr;

    assign w_load      = (r_state == ST_WAIT) & i_mem_rvalid;
    assign w_pix_valid = (r_state == ST_SHIFT) & ~w_empty;
    assign w_accept    = w_pix_valid & i_pix_ready;
    assign w_word_done = w_accept & w_last;
    assign w_tmr_done  = (r_tmr == 16'd0);
    assign w_addr      = BASE_ADDR + (r_line * LP_WPL) + r_word;

    hack_pixel_shifter #(
        .INVERT (INVERT)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (i_mem_rdata),
        .i_shift (w_accept),
        .o_pix   (w_pix),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_enable) w_next = ST_FETCH;
            ST_FETCH:  w_next = ST_WAIT;
            ST_WAIT:   if (i_mem_rvalid) w_next = ST_SHIFT;
            ST_SHIFT:  if (w_word_done) w_next = (r_word == LP_WORD_LAST) ? ST_HBLANK : ST_FETCH;
            ST_HBLANK: if (w_tmr_done) w_next = (r_line == LP_LINE_LAST) ? ST_VBLANK : ST_FETCH;
            ST_VBLANK: if (w_tmr_done) w_next = i_enable ? ST_FETCH : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Word/line position and the blanking down-counter (terminal count at 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= 16'd0;
            r_line <= 16'd0;
            r_tmr  <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_word <= 16'd0;
                        r_line <= 16'd0;
                    end
                end
                ST_SHIFT: begin
                    if (w_word_done) begin
                        if (r_word != LP_WORD_LAST) r_word <= r_word + 16'd1;
                        else                        r_tmr  <= LP_HB_LOAD;
                    end
                end
                ST_HBLANK: begin
                    if (!w_tmr_done) begin
                        r_tmr <= r_tmr - 16'd1;
                    end else if (r_line != LP_LINE_LAST) begin
                        r_line <= r_line + 16'd1;
                        r_word <= 16'd0;
                    end else begin
                        r_tmr <= LP_VB_LOAD;
                    end
                end
                ST_VBLANK: begin
                    if (!w_tmr_done) begin
                        r_tmr <= r_tmr - 16'd1;
                    end else begin
                        r_line <= 16'd0;
                        r_word <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_mem_req     = 1'b0;
        o_mem_addr    = 16'h0000;
        o_pix_valid   = w_pix_valid;
        o_pix_data    = w_pix_valid & w_pix;
        o_line_start  = w_pix_valid & w_full & (r_word == 16'd0);
        o_frame_start = w_pix_valid & w_full & (r_word == 16'd0) & (r_line == 16'd0);
        if (r_state == ST_FETCH) begin
            o_mem_req  = 1'b1;
            o_mem_addr = w_addr;
        end
    end

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Scoreboard bench for hack_screen_scanout on a 2x2-word screen, with a plain
// and an inverted instance sharing the same memory and sink.
module tb_hack_screen_scanout;

    localparam int          WPL  = 2;
    localparam int          LN   = 2;
    localparam int          HB   = 4;
    localparam int          VB   = 16;
    localparam logic [15:0] BASE = 16'h4000;

    typedef struct {
        logic pix;
        logic ls;
        logic fs;
        int   gap;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        pix_ready;

    logic        mem_req, pix_valid, pix_data, line_start, frame_start;
    logic [15:0] mem_addr;
    logic        i_mem_req, i_pix_valid, i_pix_data, i_line_start, i_frame_start;
    logic [15:0] i_mem_addr;

    exp_t        exp_q[$];
    logic [15:0] ram[4];
    int          checks, failures;
    int          pix_cnt, req_cnt, cyc;
    int          ready_mode;
    bit          gap_ok;
    bit          stale_mode;

    hack_screen_scanout #(
        .BASE_ADDR(BASE), .WORDS_PER_LINE(WPL), .LINES(LN),
        .HBLANK(HB), .VBLANK(VB), .INVERT(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_rdata(mem_rdata), .i_mem_rvalid(mem_rvalid),
        .o_pix_valid(pix_valid), .o_pix_data(pix_data), .i_pix_ready(pix_ready),
        .o_line_start(line_start), .o_frame_start(frame_start)
    );

    hack_screen_scanout #(
        .BASE_ADDR(BASE), .WORDS_PER_LINE(WPL), .LINES(LN),
        .HBLANK(HB), .VBLANK(VB), .INVERT(1'b1)
    ) dut_i (
        .clk(clk), .rst_n(rst_n), .i_enable(enable),
        .o_mem_req(i_mem_req), .o_mem_addr(i_mem_addr),
        .i_mem_rdata(mem_rdata), .i_mem_rvalid(mem_rvalid),
        .o_pix_valid(i_pix_valid), .o_pix_data(i_pix_data), .i_pix_ready(pix_ready),
        .o_line_start(i_line_start), .o_frame_start(i_frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {mem_req, mem_addr, pix_valid, pix_data, line_start, frame_start,
                   i_mem_req, i_mem_addr, i_pix_valid, i_pix_data, i_line_start, i_frame_start}, 64'd0);
    endtask

    task automatic wait_pix(input int n);
        int t;
        t = 0;
        while (pix_cnt < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("pix_progress", (pix_cnt >= n) ? n : pix_cnt, n);
    endtask

    task automatic wait_req(output bit found);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1;
                break;
            end
        end
    endtask

    // Sink: ready changes just after the active edge so it is stable for sampling.
    initial begin : ready_drv
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = ($urandom_range(3) != 0);
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // Memory model: checks the raster address order, answers after 1..3 cycles
    // and queues the 16 pixels (plus position flags) the screen should show.
    initial begin : mem_model
        int          lat;
        bit          pend;
        logic [15:0] pdata;
        int          idx, w, l;
        exp_t        e;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;
        pend = 0; lat = 0; idx = 0; req_cnt = 0; pdata = 16'h0000;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 0;
                idx  = 0;
                exp_q.delete();
            end
            if (stale_mode) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hFFFF;
            end else if (pend) begin
                lat--;
                if (lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pdata;
                    pend       = 0;
                end
            end
            if (rst_n && mem_req) begin
                req_cnt++;
                chk("mem_addr", mem_addr, BASE + 16'(idx));
                chk("inv_mem_addr", {i_mem_req, i_mem_addr}, {1'b1, BASE + 16'(idx)});
                w     = idx % WPL;
                l     = idx / WPL;
                pdata = ram[idx];
                for (int b = 0; b < 16; b++) begin
                    e.pix = pdata[b];
                    e.ls  = (b == 0) && (w == 0);
                    e.fs  = e.ls && (l == 0);
                    if (b != 15)           e.gap = 0;
                    else if (w < WPL - 1)  e.gap = 1;
                    else if (l < LN - 1)   e.gap = HB + 1;
                    else                   e.gap = HB + VB + 1;
                    exp_q.push_back(e);
                end
                pend = 1;
                lat  = $urandom_range(1, 3);
                idx  = (idx + 1) % (WPL * LN);
            end
        end
    end

    // Monitor: compares every presented pixel against the queue head; a pixel is
    // retired only when accepted, so stalls must keep the same value on the bus.
    initial begin : monitor
        bit   armed;
        int   last_c, egap;
        exp_t e;
        logic inv;
        armed = 0; last_c = 0; egap = 0; pix_cnt = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                armed = 0;
            end else begin
                if (pix_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pixel actual=%0b required=no pixel", pix_data);
                    end else begin
                        e   = exp_q[0];
                        inv = ~e.pix;
                        chk("pix_data", pix_data, e.pix);
                        chk("line_start", line_start, e.ls);
                        chk("frame_start", frame_start, e.fs);
                        chk("inv_pix", {i_pix_valid, i_pix_data}, {1'b1, inv});
                        if (pix_ready) begin
                            void'(exp_q.pop_front());
                            pix_cnt++;
                            if (e.gap != 0) begin
                                armed  = 1;
                                last_c = cyc;
                                egap   = e.gap;
                            end
                        end
                    end
                end
                if (mem_req) begin
                    chk("req_during_pix", pix_valid, 1'b0);
                    if (armed && gap_ok) chk("req_gap", cyc - last_c, egap);
                    armed = 0;
                end
            end
        end
    end

    initial begin : stim
        bit found;
        checks = 0; failures = 0;
        rst_n = 1'b0; enable = 1'b1; ready_mode = 0; gap_ok = 1; stale_mode = 0;
        ram[0] = 16'b1010101010101010;
        ram[1] = 16'b0011110011000011;
        ram[2] = 16'($urandom);
        ram[3] = 16'($urandom);

        repeat (3) begin
            @(negedge clk);
            chk_zero("reset_outputs");
        end
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mem_req) begin
                found = 1;
                break;
            end
        end
        chk("first_req_after_reset", found, 1'b1);

        wait_pix(64);

        ready_mode = 1;
        ram[2] = 16'($urandom);
        ram[3] = 16'($urandom);
        wait_pix(84);
        ready_mode = 2;
        repeat (5) @(negedge clk);
        ready_mode = 1;
        wait_pix(128);

        ram[0] = 16'h0000;
        ram[1] = 16'hFFFF;
        wait_pix(160);
        enable = 1'b0;
        gap_ok = 0;
        wait_pix(192);
        repeat (40) @(negedge clk);
        chk("req_count_3_frames", req_cnt, 12);
        chk("queue_drained", exp_q.size(), 0);
        chk_zero("idle_after_disable");

        enable = 1'b1;
        wait_req(found);
        chk("req_before_reset", found, 1'b1);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        enable     = 1'b0;
        stale_mode = 1;
        repeat (4) begin
            @(negedge clk);
            chk_zero("mid_word_reset");
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk_zero("stale_rvalid_ignored");
        end
        stale_mode = 0;
        chk("no_pix_after_reset", pix_cnt, 192);

        ram[2] = 16'($urandom);
        gap_ok = 1;
        enable = 1'b1;
        wait_req(found);
        chk("restart_req", found, 1'b1);
        enable = 1'b0;
        wait_pix(256);
        repeat (40) @(negedge clk);
        chk("req_count_final", req_cnt, 17);
        chk("queue_drained_final", exp_q.size(), 0);
        chk_zero("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
